// File: rtl/serdes_rx_aligner.sv
// Word aligner for a deserialized lane: finds SYNC_PATTERN at any bit offset of a
// two-word window, qualifies it with repeated hits, then presents aligned words.
module serdes_rx_aligner #(
  parameter int unsigned                DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]      SYNC_PATTERN = DATA_WIDTH'(8'hBC),
  parameter int unsigned                LOCK_COUNT   = 4,
  parameter int unsigned                ERR_COUNT    = 4,
  parameter int unsigned                TIMEOUT_CYC  = 256
) (
  input  logic                          rxclk,
  input  logic                          rx_reset_n,
  input  logic                          enable,
  input  logic                          rx_align,
  input  logic [DATA_WIDTH-1:0]         rx_data_in,
  output logic [DATA_WIDTH-1:0]         rx_data_out,
  output logic                          rx_locked,
  output logic                          rx_valid,
  output logic [$clog2(DATA_WIDTH)-1:0] align_offset
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH);
  localparam int unsigned HIT_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ERR_W = $clog2(ERR_COUNT + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_COUNT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic [HIT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  locked_q, locked_d;

  logic [DATA_WIDTH-1:0] cand [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] match_vec;
  logic [OFF_W-1:0]      first_idx;
  logic                  any_match;
  logic                  hit_at_off;
  logic [HIT_W-1:0]      hit_inc;
  logic [ERR_W-1:0]      err_inc;
  logic [TMR_W-1:0]      timer_inc;

  // Candidate k is the DATA_WIDTH-bit slice of {cur, prev} starting at bit k.
  always_comb begin
    any_match = 1'b0;
    first_idx = '0;
    for (int k = 0; k < int'(DATA_WIDTH); k++) begin
      cand[k]      = DATA_WIDTH'({cur_q, prev_q} >> k);
      match_vec[k] = (cand[k] == SYNC_PATTERN);
      if (match_vec[k] && !any_match) begin
        any_match = 1'b1;
        first_idx = OFF_W'(k);
      end
    end
  end

  assign hit_at_off = match_vec[offset_q];
  assign hit_inc    = (hit_cnt_q >= HIT_MAX) ? HIT_MAX : hit_cnt_q + HIT_W'(1);
  assign err_inc    = (err_cnt_q >= ERR_MAX) ? ERR_MAX : err_cnt_q + ERR_W'(1);
  assign timer_inc  = (timer_q >= TMR_MAX)   ? TMR_MAX : timer_q + TMR_W'(1);

  always_comb begin
    state_d    = state_q;
    cur_d      = rx_data_in;
    prev_d     = cur_q;
    offset_d   = offset_q;
    hit_cnt_d  = hit_cnt_q;
    err_cnt_d  = err_cnt_q;
    timer_d    = timer_q;
    data_out_d = '0;
    valid_d    = 1'b0;

    if (enable && (state_q == ST_LOCKED)) begin
      data_out_d = cand[offset_q];
      valid_d    = 1'b1;
    end

    // Disabling the lane behaves like a soft reset of the alignment state.
    if (!enable) begin
      state_d   = ST_IDLE;
      offset_d  = '0;
      hit_cnt_d = '0;
      err_cnt_d = '0;
      timer_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (rx_align && any_match) begin
            offset_d  = first_idx;
            hit_cnt_d = HIT_W'(1);
            err_cnt_d = '0;
            timer_d   = '0;
            state_d   = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (hit_at_off) begin
            hit_cnt_d = hit_inc;
            timer_d   = '0;
            if (hit_inc == HIT_MAX) begin
              state_d   = ST_LOCKED;
              err_cnt_d = '0;
            end
          end else if (any_match) begin
            state_d   = ST_SEARCH;
            hit_cnt_d = '0;
            timer_d   = '0;
          end else begin
            timer_d = timer_inc;
            if (timer_inc == TMR_MAX) begin
              state_d   = ST_SEARCH;
              hit_cnt_d = '0;
              timer_d   = '0;
            end
          end
        end
        ST_LOCKED: begin
          // Empty windows leave the error count alone; only foreign hits count.
          if (hit_at_off) begin
            err_cnt_d = '0;
          end else if (any_match) begin
            err_cnt_d = err_inc;
            if (err_inc == ERR_MAX) begin
              state_d   = ST_SEARCH;
              err_cnt_d = '0;
              hit_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge rxclk) begin
    if (!rx_reset_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      offset_q   <= '0;
      hit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      timer_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      offset_q   <= offset_d;
      hit_cnt_q  <= hit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
    end
  end

  assign rx_data_out  = data_out_q;
  assign rx_valid     = valid_q;
  assign rx_locked    = locked_q;
  assign align_offset = offset_q;

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// Scoreboard bench for serdes_rx_aligner: stimulus queues expected aligned words
// with their due cycle; a monitor pops and compares whenever rx_valid is high.
module tb_serdes_rx_aligner;

  logic       rxclk = 1'b0;
  logic       rx_reset_n;
  logic       enable;
  logic       rx_align;
  logic [7:0] rx_data_in;
  logic [7:0] rx_data_out;
  logic       rx_locked;
  logic       rx_valid;
  logic [2:0] align_offset;

  serdes_rx_aligner #(
    .DATA_WIDTH   (8),
    .SYNC_PATTERN (8'hBC),
    .LOCK_COUNT   (3),
    .ERR_COUNT    (3),
    .TIMEOUT_CYC  (64)
  ) dut (
    .rxclk        (rxclk),
    .rx_reset_n   (rx_reset_n),
    .enable       (enable),
    .rx_align     (rx_align),
    .rx_data_in   (rx_data_in),
    .rx_data_out  (rx_data_out),
    .rx_locked    (rx_locked),
    .rx_valid     (rx_valid),
    .align_offset (align_offset)
  );

  always #5 rxclk = ~rxclk;

  // Frames of four words, word 0 in bits [7:0].
  // P0: sync at offset 0. P5: sync rotated by 5 bits (80,17). P2: sync at offset 2 (F0,02).
  localparam logic [31:0] P0     = 32'h0000_00BC;
  localparam logic [31:0] P5     = 32'h0000_1780;
  localparam logic [31:0] P5_EXP = 32'h0000_00BC;
  localparam logic [31:0] P2     = 32'h0000_02F0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always @(posedge rxclk) cyc <= cyc + 1;

  always @(negedge rxclk) begin
    if (mon_en) begin
      if (rx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: cyc=%0d data=%h, required no valid word", cyc, rx_data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.data !== rx_data_out) begin
            errors++;
            $display("FAIL data_out: cyc=%0d data=%h, required cyc=%0d data=%h",
                     cyc, rx_data_out, e.cyc, e.data);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid: cyc=%0d valid=0, required data=%h at cyc=%0d", cyc, e.data, e.cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one word, capture it at the next edge, optionally schedule its aligned output.
  task automatic send(input logic [7:0] w, input bit ev, input logic [7:0] ed);
    exp_t e;
    rx_data_in = w;
    @(posedge rxclk);
    #1;
    if (ev) begin
      e.cyc  = cyc + 2;
      e.data = ed;
      exp_q.push_back(e);
    end
  endtask

  task automatic frame(input logic [31:0] words, input logic [31:0] exps, input logic [3:0] mask);
    for (int i = 0; i < 4; i++) send(words[8*i +: 8], mask[i], exps[8*i +: 8]);
  endtask

  task automatic zeros(input int n);
    repeat (n) send(8'h00, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string name, input bit with_offset);
    check({name, "_data"},   32'(rx_data_out), 32'h0);
    check({name, "_locked"}, 32'(rx_locked),   32'h0);
    check({name, "_valid"},  32'(rx_valid),    32'h0);
    if (with_offset) check({name, "_offset"}, 32'(align_offset), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rx_reset_n = 1'b0;
    enable     = 1'b0;
    rx_align   = 1'b0;
    rx_data_in = 8'h00;
    repeat (2) @(posedge rxclk);
    #1;
    check_all_zero("reset", 1'b1);

    mon_en     = 1'b1;
    rx_reset_n = 1'b1;
    enable     = 1'b1;
    rx_align   = 1'b1;
    zeros(2);

    // Offset-0 acquisition: lock on the third hit.
    frame(P0, P0, 4'b0000);
    frame(P0, P0, 4'b0000);
    check("a_two_hits_locked", 32'(rx_locked), 32'h0);
    frame(P0, P0, 4'b1110);
    check("a_locked", 32'(rx_locked), 32'h1);
    check("a_offset", 32'(align_offset), 32'h0);
    frame(P0, P0, 4'hF);
    frame(P0, P0, 4'hF);

    // Foreign hits at offset 2; a good hit in between clears the error count.
    rx_align = 1'b0;
    frame(P2, P2, 4'hF);
    frame(P2, P2, 4'hF);
    frame(P0, P0, 4'hF);
    frame(P2, P2, 4'hF);
    frame(P2, P2, 4'hF);
    check("b_good_hit_holds_lock", 32'(rx_locked), 32'h1);
    frame(P2, P2, 4'b0001);
    check("b_unlocked", 32'(rx_locked), 32'h0);
    check("b_offset_held", 32'(align_offset), 32'h0);
    frame(P2, P2, 4'b0000);
    check("b_no_align_offset", 32'(align_offset), 32'h0);
    check("b_no_align_locked", 32'(rx_locked), 32'h0);

    // Rotated stream at offset 5.
    rx_align = 1'b1;
    frame(P5, P5_EXP, 4'b0000);
    frame(P5, P5_EXP, 4'b0000);
    check("c_two_hits_locked", 32'(rx_locked), 32'h0);
    check("c_offset_latched", 32'(align_offset), 32'h5);
    frame(P5, P5_EXP, 4'b1110);
    check("c_locked", 32'(rx_locked), 32'h1);
    check("c_offset", 32'(align_offset), 32'h5);
    frame(P5, P5_EXP, 4'hF);
    zeros(2);

    // One-cycle reset while locked, then a fresh three-hit relock.
    rx_reset_n = 1'b0;
    zeros(1);
    check_all_zero("d_reset", 1'b1);
    rx_reset_n = 1'b1;
    zeros(1);
    frame(P5, P5_EXP, 4'b0000);
    frame(P5, P5_EXP, 4'b0000);
    check("d_relock_two_hits", 32'(rx_locked), 32'h0);
    frame(P5, P5_EXP, 4'b1110);
    check("d_relocked", 32'(rx_locked), 32'h1);
    frame(P5, P5_EXP, 4'hF);
    zeros(2);

    // Enable low for one cycle while locked.
    enable = 1'b0;
    zeros(1);
    check_all_zero("e_disable", 1'b0);
    enable = 1'b1;
    zeros(1);

    // 63 idle cycles between VERIFY hits is still within the timeout.
    frame(P5, P5_EXP, 4'b0000);
    zeros(60);
    frame(P5, P5_EXP, 4'b0000);
    check("f_gap63_two_hits", 32'(rx_locked), 32'h0);
    frame(P5, P5_EXP, 4'b1110);
    check("f_gap63_locked", 32'(rx_locked), 32'h1);
    zeros(2);
    enable = 1'b0;
    zeros(1);
    enable = 1'b1;
    zeros(1);

    // 64 idle cycles in VERIFY times out; the next hit restarts the count.
    frame(P5, P5_EXP, 4'b0000);
    zeros(61);
    check("g_timeout_no_lock", 32'(rx_locked), 32'h0);
    frame(P5, P5_EXP, 4'b0000);
    frame(P5, P5_EXP, 4'b0000);
    check("g_timeout_restart", 32'(rx_locked), 32'h0);
    frame(P5, P5_EXP, 4'b1110);
    check("g_locked", 32'(rx_locked), 32'h1);
    frame(P5, P5_EXP, 4'hF);
    zeros(2);
    enable = 1'b0;
    zeros(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
